// File: rtl/commutation_ctrl.sv
// ---------------------------------------------------------------------------
// commutation_ctrl
//   Six-step commutation sequencer. Each step lasts period_active clock
//   cycles: DEAD_CYCLES of all-off blanking, then the drive pattern for the
//   current step. Direction is sampled on the last DRIVE cycle of a step.
//   Period updates are staged in period_pend and applied at step boundaries.
//   Brake has the highest priority.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   en           run enable (level)
//   dir          0 = forward (idx+1), 1 = reverse (idx-1)
//   brake        brake request (level, highest priority)
//   period_in    requested step period in clk cycles
//   period_load  one-cycle strobe capturing period_in
//   phase_out    registered 8-bit drive pattern
//   step_idx     current step index 0..5
//   step_strobe  one-cycle pulse on each step advance
//   running      high while in DEAD or DRIVE
//   cfg_err      one-cycle pulse when a period_load is rejected
// ---------------------------------------------------------------------------
module commutation_ctrl #(
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned DEAD_CYCLES    = 4,
    parameter int unsigned DEFAULT_PERIOD = 16,
    parameter logic [7:0]  BRAKE_PATTERN  = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                dir,
    input  logic                brake,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_load,
    output logic [7:0]          phase_out,
    output logic [2:0]          step_idx,
    output logic                step_strobe,
    output logic                running,
    output logic                cfg_err
);

    localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] DEAD_P    = PERIOD_W'(DEAD_CYCLES);
    localparam logic [PERIOD_W-1:0] DEF_P     = PERIOD_W'(DEFAULT_PERIOD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2,
        BRAKE = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [2:0]          idx_n;
    logic                strobe_n;
    logic                boundary;
    logic [DW-1:0]       dead_cnt, dead_n;
    logic [PERIOD_W-1:0] per_cnt, per_n;
    logic [PERIOD_W-1:0] period_active, period_pend;
    logic                load_ok;

    function automatic logic [7:0] pattern(input logic [2:0] idx);
        logic [7:0] p;
        case (idx)
            3'd0:    p = 8'b1001_0000;
            3'd1:    p = 8'b0001_1000;
            3'd2:    p = 8'b0100_1000;
            3'd3:    p = 8'b0110_0000;
            3'd4:    p = 8'b0010_0100;
            3'd5:    p = 8'b1000_0100;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    assign load_ok = period_load && (period_in > DEAD_P);

    // per_cnt tracks the position within the whole step; it is preloaded to
    // DEAD_CYCLES on entering DRIVE so the last DRIVE cycle is period_active-1.
    always_comb begin
        state_n  = state;
        idx_n    = step_idx;
        strobe_n = 1'b0;
        boundary = 1'b0;
        dead_n   = dead_cnt;
        per_n    = per_cnt;
        if (brake) begin
            state_n = BRAKE;
            dead_n  = '0;
            per_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state_n = DEAD;
                        dead_n  = '0;
                        per_n   = '0;
                    end
                end
                DEAD: begin
                    if (!en) begin
                        state_n = IDLE;
                        dead_n  = '0;
                        per_n   = '0;
                    end else if (dead_cnt == DEAD_LAST) begin
                        state_n = DRIVE;
                        dead_n  = '0;
                        per_n   = DEAD_P;
                    end else begin
                        dead_n = dead_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (!en) begin
                        state_n = IDLE;
                        dead_n  = '0;
                        per_n   = '0;
                    end else if (per_cnt == period_active - 1'b1) begin
                        state_n  = DEAD;
                        boundary = 1'b1;
                        strobe_n = 1'b1;
                        dead_n   = '0;
                        per_n    = '0;
                        if (dir)
                            idx_n = (step_idx == 3'd0) ? 3'd5 : step_idx - 3'd1;
                        else
                            idx_n = (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;
                    end else begin
                        per_n = per_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    dead_n  = '0;
                    per_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            step_idx      <= '0;
            phase_out     <= '0;
            step_strobe   <= 1'b0;
            running       <= 1'b0;
            cfg_err       <= 1'b0;
            dead_cnt      <= '0;
            per_cnt       <= '0;
            period_active <= DEF_P;
            period_pend   <= DEF_P;
        end else begin
            state       <= state_n;
            step_idx    <= idx_n;
            step_strobe <= strobe_n;
            dead_cnt    <= dead_n;
            per_cnt     <= per_n;
            running     <= (state_n == DEAD) || (state_n == DRIVE);
            cfg_err     <= period_load && !load_ok;

            case (state_n)
                DRIVE:   phase_out <= pattern(idx_n);
                BRAKE:   phase_out <= BRAKE_PATTERN;
                default: phase_out <= '0;
            endcase

            // Boundary takes the previously pending value; a load on the
            // same cycle lands in period_pend only.
            if (boundary)
                period_active <= period_pend;
            if (load_ok) begin
                period_pend <= period_in;
                if (state == IDLE)
                    period_active <= period_in;
            end
        end
    end

endmodule

// File: tb/tb_commutation_ctrl.sv
module tb_commutation_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic        brake = 1'b0;
    logic [15:0] period_in = '0;
    logic        period_load = 1'b0;
    logic [7:0]  phase_out;
    logic [2:0]  step_idx;
    logic        step_strobe;
    logic        running;
    logic        cfg_err;

    localparam logic [7:0] BP = 8'hC3;

    always #5 clk = ~clk;

    commutation_ctrl #(
        .PERIOD_W(16),
        .DEAD_CYCLES(4),
        .DEFAULT_PERIOD(16),
        .BRAKE_PATTERN(BP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .dir(dir),
        .brake(brake),
        .period_in(period_in),
        .period_load(period_load),
        .phase_out(phase_out),
        .step_idx(step_idx),
        .step_strobe(step_strobe),
        .running(running),
        .cfg_err(cfg_err)
    );

    typedef struct {
        int          n;
        logic        rst;
        logic        en;
        logic        dir;
        logic        brk;
        logic        ld;
        logic [15:0] pin;
        logic [7:0]  ph;
        logic [2:0]  idx;
        logic        stb;
        logic        run;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic r(input int n, input logic e, input logic d, input logic b,
                     input logic ld, input logic [15:0] pin,
                     input logic [7:0] ph, input logic [2:0] idx,
                     input logic stb, input logic run, input logic err);
        vec_t v;
        v.n = n; v.rst = 1'b0; v.en = e; v.dir = d; v.brk = b; v.ld = ld;
        v.pin = pin; v.ph = ph; v.idx = idx; v.stb = stb; v.run = run; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic rst_row();
        vec_t v;
        v.n = 1; v.rst = 1'b1; v.en = 1'b0; v.dir = 1'b0; v.brk = 1'b0; v.ld = 1'b0;
        v.pin = '0; v.ph = '0; v.idx = '0; v.stb = 1'b0; v.run = 1'b0; v.err = 1'b0;
        vecs.push_back(v);
    endtask

    // One running step from its boundary: strobe cycle, rest of dead, drive.
    task automatic step(input logic d, input logic [2:0] idx, input logic [7:0] ph, input int drive_n);
        r(1, 1, d, 0, 0, 0, 8'h00, idx, 1, 1, 0);
        r(3, 1, d, 0, 0, 0, 8'h00, idx, 0, 1, 0);
        r(drive_n, 1, d, 0, 0, 0, ph, idx, 0, 1, 0);
    endtask

    task automatic check(input string name, input int row);
        tests++;
        if ({phase_out, step_idx, step_strobe, running, cfg_err} !==
            {vecs[row].ph, vecs[row].idx, vecs[row].stb, vecs[row].run, vecs[row].err}) begin
            fails++;
            $display("FAIL %s row %0d t=%0t: got ph=%h idx=%0d stb=%b run=%b err=%b, exp ph=%h idx=%0d stb=%b run=%b err=%b",
                     name, row, $time, phase_out, step_idx, step_strobe, running, cfg_err,
                     vecs[row].ph, vecs[row].idx, vecs[row].stb, vecs[row].run, vecs[row].err);
        end
    endtask

    initial begin
        // reset, idle, then forward run over a full revolution
        rst_row();
        r(2, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        r(4, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        r(12, 1, 0, 0, 0, 0, 8'h90, 0, 0, 1, 0);
        step(0, 1, 8'h18, 12);
        step(0, 2, 8'h48, 12);
        step(0, 3, 8'h60, 12);
        step(0, 4, 8'h24, 12);
        step(0, 5, 8'h84, 12);
        step(0, 0, 8'h90, 12);
        // reverse wrap 0->5, then dir toggled mid-DRIVE; only the last cycle counts
        step(1, 5, 8'h84, 12);
        r(1, 1, 1, 0, 0, 0, 8'h00, 4, 1, 1, 0);
        r(3, 1, 1, 0, 0, 0, 8'h00, 4, 0, 1, 0);
        r(6, 1, 1, 0, 0, 0, 8'h24, 4, 0, 1, 0);
        r(6, 1, 0, 0, 0, 0, 8'h24, 4, 0, 1, 0);
        r(1, 1, 1, 0, 0, 0, 8'h00, 3, 1, 1, 0);
        r(3, 1, 1, 0, 0, 0, 8'h00, 3, 0, 1, 0);
        // disable mid-DRIVE at step 3, resume with full dead and no strobe
        r(5, 1, 0, 0, 0, 0, 8'h60, 3, 0, 1, 0);
        r(3, 0, 0, 0, 0, 0, 8'h00, 3, 0, 0, 0);
        r(4, 1, 0, 0, 0, 0, 8'h00, 3, 0, 1, 0);
        r(12, 1, 0, 0, 0, 0, 8'h60, 3, 0, 1, 0);
        // period 40 loaded mid-step: current step stays 16
        r(1, 1, 0, 0, 0, 0, 8'h00, 4, 1, 1, 0);
        r(3, 1, 0, 0, 0, 0, 8'h00, 4, 0, 1, 0);
        r(4, 1, 0, 0, 0, 0, 8'h24, 4, 0, 1, 0);
        r(1, 1, 0, 0, 1, 16'd40, 8'h24, 4, 0, 1, 0);
        r(7, 1, 0, 0, 0, 0, 8'h24, 4, 0, 1, 0);
        step(0, 5, 8'h84, 36);
        // rejected load of 4 pulses cfg_err, period stays 40
        r(1, 1, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0);
        r(3, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        r(10, 1, 0, 0, 0, 0, 8'h90, 0, 0, 1, 0);
        r(1, 1, 0, 0, 1, 16'd4, 8'h90, 0, 0, 1, 1);
        r(25, 1, 0, 0, 0, 0, 8'h90, 0, 0, 1, 0);
        // load of 20 on the boundary: next step still 40, the one after 20
        r(1, 1, 0, 0, 1, 16'd20, 8'h00, 1, 1, 1, 0);
        r(3, 1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0);
        r(36, 1, 0, 0, 0, 0, 8'h18, 1, 0, 1, 0);
        step(0, 2, 8'h48, 16);
        step(0, 3, 8'h60, 16);
        // brake on the would-be boundary: no advance, no strobe
        r(1, 1, 0, 1, 0, 0, BP, 3, 0, 0, 0);
        r(2, 1, 0, 1, 0, 0, BP, 3, 0, 0, 0);
        r(1, 1, 0, 0, 0, 0, 8'h00, 3, 0, 0, 0);
        r(4, 1, 0, 0, 0, 0, 8'h00, 3, 0, 1, 0);
        r(16, 1, 0, 0, 0, 0, 8'h60, 3, 0, 1, 0);
        step(0, 4, 8'h24, 5);
        // reset mid-DRIVE, then default period again from step 0
        rst_row();
        r(4, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        r(12, 1, 0, 0, 0, 0, 8'h90, 0, 0, 1, 0);
        step(0, 1, 8'h18, 3);
        // load in IDLE applies immediately to the resumed step
        r(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        r(1, 0, 0, 0, 1, 16'd24, 8'h00, 1, 0, 0, 0);
        r(4, 1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0);
        r(20, 1, 0, 0, 0, 0, 8'h18, 1, 0, 1, 0);
        r(1, 1, 0, 0, 0, 0, 8'h00, 2, 1, 1, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                en = 1'b0; dir = 1'b0; brake = 1'b0; period_load = 1'b0; period_in = '0;
                #1;
                check("async_reset", i);
                @(posedge clk);
                #1;
                check("held_reset", i);
                rst_n = 1'b1;
            end else begin
                for (int k = 0; k < vecs[i].n; k++) begin
                    en = vecs[i].en;
                    dir = vecs[i].dir;
                    brake = vecs[i].brk;
                    period_load = vecs[i].ld;
                    period_in = vecs[i].pin;
                    @(posedge clk);
                    #1;
                    check("vector", i);
                end
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
